// File: rtl/ts4231_config_sequencer.sv
// Wakes each TS4231 sensor in turn: wait for light, write the config word, read it back,
// then command watch state. All pads are released once the last sensor is handled.
module ts4231_config_sequencer #(
  parameter int          N_SENSORS     = 4,
  parameter int          BIT_DIV       = 6,
  parameter int          LIGHT_TIMEOUT = 2400000,
  parameter logic [14:0] CONFIG_WORD   = 15'h392B
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [N_SENSORS-1:0] e_in,
  input  logic [N_SENSORS-1:0] d_in,
  output logic [N_SENSORS-1:0] e_oe,
  output logic [N_SENSORS-1:0] e_out,
  output logic [N_SENSORS-1:0] d_oe,
  output logic [N_SENSORS-1:0] d_out,
  output logic                 busy,
  output logic                 done,
  output logic [N_SENSORS-1:0] sensor_ok,
  output logic [N_SENSORS-1:0] sensor_err
);
  localparam int IDX_W  = (N_SENSORS > 1) ? $clog2(N_SENSORS) : 1;
  localparam int HALF_W = $clog2(BIT_DIV);
  localparam int TMO_W  = $clog2(LIGHT_TIMEOUT + 1);
  localparam logic [HALF_W-1:0] HALF_MAX = HALF_W'(BIT_DIV - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(LIGHT_TIMEOUT - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(N_SENSORS - 1);

  typedef enum logic [3:0] {
    IDLE, LIGHT, WR_START, WR_BIT, WR_STOP, RD_START, RD_BIT, CHECK, WATCH, NEXT
  } state_t;

  state_t                 state_reg, state_next;
  logic [1:0]             phase_reg, phase_next;
  logic [3:0]             bit_reg, bit_next;
  logic [HALF_W-1:0]      half_reg, half_next;
  logic [TMO_W-1:0]       timer_reg, timer_next;
  logic [IDX_W-1:0]       idx_reg, idx_next;
  logic [14:0]            shift_reg, shift_next;
  logic [N_SENSORS-1:0]   ok_reg, ok_next, err_reg, err_next;
  logic                   busy_reg, busy_next, done_reg, done_next;
  logic [N_SENSORS-1:0]   e_meta_reg, e_sync_reg, e_prev_reg, d_meta_reg, d_sync_reg;
  logic [N_SENSORS-1:0]   e_oe_reg, e_out_reg, d_oe_reg, d_out_reg;
  logic [N_SENSORS-1:0]   sel_next;
  logic                   half_done, e_rise, timed;
  logic                   eo_next, ev_next, do_next, dv_next;

  assign half_done = (half_reg == '0);
  assign e_rise    = e_sync_reg[idx_reg] & ~e_prev_reg[idx_reg];
  assign timed     = (state_reg inside {WR_START, WR_BIT, WR_STOP, RD_START, RD_BIT, WATCH});

  genvar gi;
  generate
    for (gi = 0; gi < N_SENSORS; gi++) begin : g_sel
      assign sel_next[gi] = (idx_next == IDX_W'(gi));
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    phase_next = phase_reg;
    bit_next   = bit_reg;
    half_next  = HALF_MAX;
    timer_next = timer_reg;
    idx_next   = idx_reg;
    shift_next = shift_reg;
    ok_next    = ok_reg;
    err_next   = err_reg;
    busy_next  = busy_reg;
    done_next  = 1'b0;
    if (timed && !half_done) half_next = half_reg - HALF_W'(1);
    case (state_reg)
      IDLE: begin
        // a start coinciding with the done pulse is dropped
        if (start && !done_reg) begin
          idx_next   = '0;
          ok_next    = '0;
          err_next   = '0;
          busy_next  = 1'b1;
          timer_next = '0;
          state_next = LIGHT;
        end
      end
      LIGHT: begin
        if (e_rise) begin
          phase_next = 2'd0;
          state_next = WR_START;
        end else if (timer_reg == TMO_LAST) begin
          err_next[idx_reg] = 1'b1;
          state_next        = NEXT;
        end else begin
          timer_next = timer_reg + TMO_W'(1);
        end
      end
      WR_START: if (half_done) begin
        if (phase_reg == 2'd2) begin
          phase_next = 2'd0;
          bit_next   = 4'd14;
          state_next = WR_BIT;
        end else phase_next = phase_reg + 2'd1;
      end
      WR_BIT: if (half_done) begin
        if (phase_reg == 2'd2) begin
          phase_next = 2'd0;
          if (bit_reg == 4'd0) state_next = WR_STOP;
          else bit_next = bit_reg - 4'd1;
        end else phase_next = phase_reg + 2'd1;
      end
      WR_STOP: if (half_done) begin
        if (phase_reg == 2'd2) begin
          phase_next = 2'd0;
          state_next = RD_START;
        end else phase_next = phase_reg + 2'd1;
      end
      RD_START: if (half_done) begin
        phase_next = 2'd0;
        bit_next   = 4'd14;
        state_next = RD_BIT;
      end
      RD_BIT: if (half_done) begin
        if (phase_reg == 2'd0) begin
          shift_next = {shift_reg[13:0], d_sync_reg[idx_reg]};
          phase_next = 2'd1;
        end else begin
          phase_next = 2'd0;
          if (bit_reg == 4'd0) state_next = CHECK;
          else bit_next = bit_reg - 4'd1;
        end
      end
      CHECK: begin
        if (shift_reg == CONFIG_WORD) begin
          phase_next = 2'd0;
          state_next = WATCH;
        end else begin
          err_next[idx_reg] = 1'b1;
          state_next        = NEXT;
        end
      end
      WATCH: if (half_done) begin
        if (phase_reg == 2'd2) begin
          ok_next[idx_reg] = 1'b1;
          state_next       = NEXT;
        end else phase_next = phase_reg + 2'd1;
      end
      NEXT: begin
        if (idx_reg == IDX_LAST) begin
          done_next  = 1'b1;
          busy_next  = 1'b0;
          state_next = IDLE;
        end else begin
          idx_next   = idx_reg + IDX_W'(1);
          timer_next = '0;
          state_next = LIGHT;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Pad drive is decoded from the next state so the pins change on the same edge as the FSM
  always_comb begin
    eo_next = 1'b0;
    ev_next = 1'b0;
    do_next = 1'b0;
    dv_next = 1'b0;
    case (state_next)
      WR_START: begin eo_next = 1'b1; do_next = 1'b1; ev_next = (phase_next != 2'd2); dv_next = (phase_next == 2'd0); end
      WR_BIT:   begin eo_next = 1'b1; do_next = 1'b1; ev_next = (phase_next == 2'd1); dv_next = CONFIG_WORD[bit_next]; end
      WR_STOP:  begin eo_next = 1'b1; do_next = 1'b1; ev_next = (phase_next != 2'd0); dv_next = (phase_next == 2'd2); end
      RD_START: eo_next = 1'b1;
      RD_BIT:   begin eo_next = 1'b1; ev_next = (phase_next == 2'd0); end
      CHECK:    eo_next = 1'b1;
      WATCH:    begin eo_next = (phase_next != 2'd2); ev_next = (phase_next == 2'd1); do_next = 1'b1; dv_next = 1'b1; end
      default:  ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= IDLE;
      phase_reg  <= '0;
      bit_reg    <= '0;
      half_reg   <= HALF_MAX;
      timer_reg  <= '0;
      idx_reg    <= '0;
      shift_reg  <= '0;
      ok_reg     <= '0;
      err_reg    <= '0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      e_meta_reg <= '0;
      e_sync_reg <= '0;
      e_prev_reg <= '0;
      d_meta_reg <= '0;
      d_sync_reg <= '0;
      e_oe_reg   <= '0;
      e_out_reg  <= '0;
      d_oe_reg   <= '0;
      d_out_reg  <= '0;
    end else begin
      state_reg  <= state_next;
      phase_reg  <= phase_next;
      bit_reg    <= bit_next;
      half_reg   <= half_next;
      timer_reg  <= timer_next;
      idx_reg    <= idx_next;
      shift_reg  <= shift_next;
      ok_reg     <= ok_next;
      err_reg    <= err_next;
      busy_reg   <= busy_next;
      done_reg   <= done_next;
      e_meta_reg <= e_in;
      e_sync_reg <= e_meta_reg;
      e_prev_reg <= e_sync_reg;
      d_meta_reg <= d_in;
      d_sync_reg <= d_meta_reg;
      e_oe_reg   <= eo_next ? sel_next : '0;
      e_out_reg  <= (eo_next && ev_next) ? sel_next : '0;
      d_oe_reg   <= do_next ? sel_next : '0;
      d_out_reg  <= (do_next && dv_next) ? sel_next : '0;
    end
  end

  assign e_oe       = e_oe_reg;
  assign e_out      = e_out_reg;
  assign d_oe       = d_oe_reg;
  assign d_out      = d_out_reg;
  assign busy       = busy_reg;
  assign done       = done_reg;
  assign sensor_ok  = ok_reg;
  assign sensor_err = err_reg;
endmodule

// File: tb/tb_ts4231_config_sequencer.sv
// Directed bench for ts4231_config_sequencer with a pin-level TS4231 echo model and pulsed light.
module tb_ts4231_config_sequencer;
  localparam int          N   = 4;
  localparam int          BD  = 6;
  localparam int          TMO = 100;
  localparam logic [14:0] CW  = 15'h392B;

  logic         clk = 1'b0;
  logic         reset, start;
  logic [N-1:0] e_in, d_in, e_oe, e_out, d_oe, d_out, sensor_ok, sensor_err;
  logic         busy, done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [N-1:0] light_en, bad_mask;
  int           light_t0;

  // sensor model state
  logic [14:0] wr_word [N];
  int          wr_cnt [N];
  int          rd_cnt [N];
  logic [N-1:0] e_last;

  // monitor state
  int   done_cnt = 0, t_done = 0, t_ok1 = 0, t_err2 = 0, oe1_viol = 0;
  int   eoe0_run = 0, eoe0_len = 0, wr_rise = 0, t_r1 = 0, t_r2 = 0, w1 = 0;
  logic ok1_last = 1'b0, err2_last = 1'b0, mon_e_last = 1'b0;

  ts4231_config_sequencer #(
    .N_SENSORS(N), .BIT_DIV(BD), .LIGHT_TIMEOUT(TMO), .CONFIG_WORD(CW)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .e_in(e_in), .d_in(d_in),
    .e_oe(e_oe), .e_out(e_out), .d_oe(d_oe), .d_out(d_out),
    .busy(busy), .done(done), .sensor_ok(sensor_ok), .sensor_err(sensor_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // TS4231 model: E follows light flashes (every 32 clocks from 24 clocks after start),
  // write bits are captured on E rises while D is driven, and read back on E rises while D is released.
  always @(negedge clk) begin
    int          lt;
    logic        light;
    logic [14:0] reply;
    for (int i = 0; i < N; i++) begin
      lt    = cyc - light_t0;
      light = light_en[i] && (lt >= 24) && (((lt - 24) % 32) < 4);
      e_in[i] = e_oe[i] ? e_out[i] : light;
      if (!busy) begin
        wr_cnt[i] = 0;
        rd_cnt[i] = 0;
        d_in[i]   = 1'b0;
      end else if (e_oe[i] && e_out[i] && !e_last[i]) begin
        if (d_oe[i]) begin
          if (wr_cnt[i] >= 1 && wr_cnt[i] <= 15) wr_word[i] = {wr_word[i][13:0], d_out[i]};
          wr_cnt[i] = wr_cnt[i] + 1;
        end else if (rd_cnt[i] < 15) begin
          reply     = wr_word[i] ^ (bad_mask[i] ? 15'h0001 : 15'h0000);
          d_in[i]   = reply[14 - rd_cnt[i]];
          rd_cnt[i] = rd_cnt[i] + 1;
        end
      end
      e_last[i] = e_oe[i] & e_out[i];
    end
  end

  always @(negedge clk) begin
    if (done) begin done_cnt = done_cnt + 1; t_done = cyc; end
    if (sensor_ok[1] && !ok1_last) t_ok1 = cyc;
    if (sensor_err[2] && !err2_last) t_err2 = cyc;
    ok1_last  = sensor_ok[1];
    err2_last = sensor_err[2];
    if (busy && sensor_err[1] && (e_oe[1] || d_oe[1])) oe1_viol = oe1_viol + 1;
    if (e_oe[0]) eoe0_run = eoe0_run + 1;
    else if (eoe0_run > 0) begin eoe0_len = eoe0_run; eoe0_run = 0; end
    if (!busy) wr_rise = 0;
    else if (e_oe[0] && e_out[0] && !mon_e_last && d_oe[0]) begin
      if (wr_rise == 1) t_r1 = cyc;
      if (wr_rise == 2) t_r2 = cyc;
      wr_rise = wr_rise + 1;
    end else if (mon_e_last && !(e_oe[0] && e_out[0]) && wr_rise == 2) begin
      w1 = cyc - t_r1;
    end
    mon_e_last = e_oe[0] & e_out[0];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_start();
    @(negedge clk);
    start    = 1'b1;
    light_t0 = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  // returns at the negedge where done is seen, or after the cycle budget expires
  task automatic wait_done(input string tag, output int t_start_rel);
    int n;
    n = 0;
    while (!done && n < 6000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done_seen"}, 32'(done), 32'd1);
    t_start_rel = cyc - light_t0;
  endtask

  int lat_happy, lat_busy, lat_tmp, dc0, viol0, n;

  initial begin
    reset = 1'b1; start = 1'b0; light_en = '0; bad_mask = '0; light_t0 = 0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_pads", 32'({e_oe, e_out, d_oe, d_out}), 32'd0);
    chk("rst_ok", 32'(sensor_ok), 32'd0);
    chk("rst_err", 32'(sensor_err), 32'd0);
    @(negedge clk); reset = 1'b0;
    repeat (2) @(negedge clk);

    // happy path
    light_en = 4'b1111; bad_mask = '0; dc0 = done_cnt;
    run_start();
    chk("busy_rise", 32'(busy), 32'd1);
    wait_done("happy", lat_happy);
    repeat (5) @(negedge clk);
    chk("happy_ok", 32'(sensor_ok), 32'hF);
    chk("happy_err", 32'(sensor_err), 32'h0);
    chk("happy_done_cnt", 32'(done_cnt - dc0), 32'd1);
    chk("happy_busy_low", 32'(busy), 32'd0);
    for (int i = 0; i < N; i++) chk($sformatf("wr_word%0d", i), 32'(wr_word[i]), 32'(CW));
    chk("e_oe0_len", 32'(eoe0_len), 32'(84 * BD + 1));
    chk("bit_e_width", 32'(w1), 32'(BD));
    chk("bit_period", 32'(t_r2 - t_r1), 32'(3 * BD));
    $display("txn happy: done %0d clocks after start, ok=%b err=%b", lat_happy, sensor_ok, sensor_err);

    // start while busy is ignored
    dc0 = done_cnt;
    run_start();
    repeat (48) @(negedge clk);
    start = 1'b1; @(negedge clk); start = 1'b0;
    wait_done("busy_start", lat_busy);
    repeat (5) @(negedge clk);
    chk("busy_start_latency", 32'(lat_busy), 32'(lat_happy));
    chk("busy_start_ok", 32'(sensor_ok), 32'hF);
    chk("busy_start_done_cnt", 32'(done_cnt - dc0), 32'd1);
    $display("txn start-while-busy: done %0d clocks after start", lat_busy);

    // no light on sensor 2
    light_en = 4'b1011;
    run_start();
    wait_done("nolight", lat_tmp);
    repeat (5) @(negedge clk);
    chk("nolight_timeout", 32'(t_err2 - t_ok1), 32'(TMO + 1));
    chk("nolight_ok", 32'(sensor_ok), 32'b1011);
    chk("nolight_err", 32'(sensor_err), 32'b0100);
    $display("txn no-light: ok=%b err=%b", sensor_ok, sensor_err);

    // readback mismatch on sensor 1, plus a start coinciding with done
    light_en = 4'b1111; bad_mask = 4'b0010; viol0 = oe1_viol;
    run_start();
    wait_done("mismatch", lat_tmp);
    start = 1'b1; @(negedge clk); start = 1'b0;
    chk("start_on_done_ignored", 32'(busy), 32'd0);
    repeat (5) @(negedge clk);
    chk("mismatch_err", 32'(sensor_err), 32'b0010);
    chk("mismatch_ok", 32'(sensor_ok), 32'b1101);
    chk("mismatch_oe_after_check", 32'(oe1_viol - viol0), 32'd0);
    $display("txn mismatch: ok=%b err=%b", sensor_ok, sensor_err);

    // reset during bit 7 of sensor 0
    bad_mask = '0;
    run_start();
    n = 0;
    while (wr_rise < 8 && n < 2000) begin @(negedge clk); n++; end
    chk("reach_bit7", 32'(wr_rise >= 8), 32'd1);
    reset = 1'b1;
    #1;
    chk("async_rst_e_oe", 32'(e_oe), 32'd0);
    chk("async_rst_d_oe", 32'(d_oe), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    @(negedge clk); reset = 1'b0;
    repeat (2) @(negedge clk);
    run_start();
    wait_done("after_reset", lat_tmp);
    repeat (5) @(negedge clk);
    chk("after_reset_ok", 32'(sensor_ok), 32'hF);
    chk("after_reset_err", 32'(sensor_err), 32'h0);
    $display("txn reset-mid-write rerun: ok=%b err=%b", sensor_ok, sensor_err);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
